// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and constants for the commit trace buffer: state encoding,
// capture modes and the packed record width.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MODE_FILLSTOP = 0;
  localparam int MODE_CIRCULAR = 1;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int WB_EN_W    = 1;

  // Record layout, MSB first: {pc, instr, wb_en, wb_addr, wb_data}
  function automatic int rec_w(input int data_w, input int reg_aw);
    return 3 * data_w + WB_EN_W + reg_aw;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit snoop, capture control and record readout signals of the trace buffer.
interface commit_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 512
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              i_commit_valid;
  logic [DATA_W-1:0] i_commit_pc;
  logic [DATA_W-1:0] i_commit_instr;
  logic              i_wb_en;
  logic [REG_AW-1:0] i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;
  logic              i_arm;
  logic [DATA_W-1:0] i_trig_pc;
  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [DATA_W-1:0] o_rd_pc;
  logic [DATA_W-1:0] o_rd_instr;
  logic [DATA_W-1:0] o_rd_wb_data;
  logic              o_rd_wb_en;
  logic [REG_AW-1:0] o_rd_wb_addr;
  logic [1:0]        o_state;
  logic [CW-1:0]     o_count;
  logic              o_overflow;
  logic              o_done;

  modport slave (
    input  i_commit_valid, i_commit_pc, i_commit_instr, i_wb_en, i_wb_addr,
           i_wb_data, i_arm, i_trig_pc, i_rd_ready,
    output o_rd_valid, o_rd_pc, o_rd_instr, o_rd_wb_data, o_rd_wb_en,
           o_rd_wb_addr, o_state, o_count, o_overflow, o_done
  );

  modport master (
    output i_commit_valid, i_commit_pc, i_commit_instr, i_wb_en, i_wb_addr,
           i_wb_data, i_arm, i_trig_pc, i_rd_ready,
    input  o_rd_valid, o_rd_pc, o_rd_instr, o_rd_wb_data, o_rd_wb_en,
           o_rd_wb_addr, o_state, o_count, o_overflow, o_done
  );

endinterface

// File: rtl/commit_trace_buffer_ram.sv
// Simple dual-port record store: synchronous write, registered read whose
// output holds its value whenever no read is issued.
module trace_ram #(
  parameter int DEPTH = 512,
  parameter int RW    = 102
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [RW-1:0]            wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [RW-1:0]            rdata_o
);

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // The read register doubles as the readout prefetch stage.
  always_ff @(posedge clk) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-stream trace buffer: captures retiring instructions into a ring with
// arm/trigger/post-trigger control, then drains them oldest-first over valid/ready.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 512,
  parameter int POST_TRIG = 16,
  parameter int MODE      = 1
) (
  input logic                  clk,
  input logic                  reset,
  commit_trace_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
  localparam int RW = rec_w(DATA_W, REG_AW);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [PW-1:0] POST_LOAD = PW'(POST_TRIG);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, issue_q, issue_d;
  logic [PW-1:0] post_q, post_d;
  logic          ovf_q, ovf_d, done_q, done_d, rvld_q, rvld_d;
  logic          we, re, xfer, hit;
  logic [RW-1:0] wrec, rrec;

  assign xfer = rvld_q && bus.i_rd_ready;
  assign hit  = (bus.i_commit_pc == bus.i_trig_pc);
  assign wrec = {bus.i_commit_pc, bus.i_commit_instr, bus.i_wb_en,
                 bus.i_wb_addr, bus.i_wb_data};

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    issue_d = issue_q;
    post_d  = post_q;
    ovf_d   = ovf_q;
    rvld_d  = rvld_q;
    done_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    if (bus.i_arm) begin
      state_d = ST_ARMED;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      issue_d = '0;
      ovf_d   = 1'b0;
      rvld_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          if (bus.i_commit_valid) begin
            we     = 1'b1;
            wptr_d = wptr_q + AW'(1);
            if (count_q == FULL) begin
              if (MODE == MODE_CIRCULAR) ovf_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            if (MODE == MODE_FILLSTOP) begin
              if (count_d == FULL) state_d = ST_DONE;
            end else if (state_q == ST_ARMED) begin
              if (hit) begin
                post_d  = POST_LOAD;
                state_d = (POST_TRIG == 0) ? ST_DONE : ST_POST;
              end
            end else begin
              post_d = post_q - PW'(1);
              if (post_q == PW'(1)) state_d = ST_DONE;
            end
            // A full ring starts at the slot about to be overwritten next.
            if (state_d == ST_DONE) begin
              rptr_d  = (count_d == FULL) ? wptr_d : '0;
              issue_d = count_d;
            end
          end
        end
        ST_DONE: begin
          re = (issue_q != '0) && (!rvld_q || xfer);
          if (re) begin
            rptr_d  = rptr_q + AW'(1);
            issue_d = issue_q - CW'(1);
          end
          rvld_d = re || (rvld_q && !xfer);
          if (xfer) count_d = count_q - CW'(1);
          if (count_d == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      issue_q <= '0;
      post_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      issue_q <= issue_d;
      post_q  <= post_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      rvld_q  <= rvld_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .RW    (RW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (wrec),
    .re_i    (re),
    .raddr_i (rptr_q),
    .rdata_o (rrec)
  );

  assign bus.o_rd_valid   = rvld_q;
  assign bus.o_rd_pc      = rrec[RW-1 -: DATA_W];
  assign bus.o_rd_instr   = rrec[RW-DATA_W-1 -: DATA_W];
  assign bus.o_rd_wb_en   = rrec[DATA_W+REG_AW];
  assign bus.o_rd_wb_addr = rrec[DATA_W +: REG_AW];
  assign bus.o_rd_wb_data = rrec[DATA_W-1:0];
  assign bus.o_state      = state_q;
  assign bus.o_count      = count_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_done       = done_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable, parametrised successor to the per-cycle pc/instr/register dump used in core bring-up. Sits beside core0 in MotherBoard and snoops the MEM/WB commit stream (pc, instr, GPR write). Captures records into an on-chip ring buffer with arm/trigger/post-trigger control. Drains captured records in order over a valid/ready port for a debug bridge or bench.

Parameters:
DATA_W, 32, width of pc, instr and write-back data
REG_AW, 5, GPR address width
DEPTH, 512, record slots; power of two, at least 4
POST_TRIG, 16, records captured after the trigger record (0 allowed)
MODE, 1, 0 = fill-stop (no trigger, stop when full); 1 = circular pre-trigger with PC trigger

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_commit_valid  in  1  one instruction retires this cycle
i_commit_pc  in  DATA_W  pc of retiring instruction
i_commit_instr  in  DATA_W  instruction word
i_wb_en  in  1  retiring instruction writes a GPR
i_wb_addr  in  REG_AW  GPR index written
i_wb_data  in  DATA_W  value written
i_arm  in  1  one-cycle pulse: clear buffer and start capture
i_trig_pc  in  DATA_W  trigger pc (MODE 1)
o_rd_valid  out  1  read record available
i_rd_ready  in  1  consumer accepts record
o_rd_pc / o_rd_instr / o_rd_wb_data  out  DATA_W  record fields
o_rd_wb_en  out  1  record field
o_rd_wb_addr  out  REG_AW  record field
o_state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3
o_count  out  clog2(DEPTH+1)  valid records held
o_overflow  out  1  at least one record was overwritten
o_done  out  1  one-cycle pulse when the last record drains

Behaviour:
- Reset, from any state: IDLE, write pointer and read pointer 0, o_count 0, o_overflow 0, o_rd_valid 0, o_done 0, all o_rd_* data 0.
- Record = {pc, instr, wb_en, wb_addr, wb_data}. Written only on i_commit_valid in ARMED or POST. Commits are ignored in IDLE and DONE.
- i_arm, any state: next cycle is ARMED with pointers, count and overflow cleared. A commit in the same cycle as i_arm is dropped. i_arm in DONE aborts readout and deasserts o_rd_valid.
- ARMED, each write: wptr = (wptr+1) mod DEPTH; count saturates at DEPTH.
- MODE 0: the write that makes count == DEPTH moves the state to DONE. No overwrites occur; o_overflow stays 0.
- MODE 1, write when count == DEPTH: overwrites the oldest record and sets o_overflow (sticky until arm or reset).
- MODE 1 trigger: i_commit_valid && pc == i_trig_pc in ARMED. The trigger record is written, and the post counter loads POST_TRIG.
  - If POST_TRIG == 0, the next state is DONE.
  - Otherwise the next state is POST.
- POST: each write decrements the post counter (overwriting allowed). The write that reaches 0 moves the state to DONE. i_trig_pc is ignored in POST.
- Entering DONE: rptr = (count == DEPTH) ? wptr : 0, i.e. the oldest record. remaining = count.
- Readout uses a 1-cycle RAM read. o_rd_valid rises 1 cycle after entering DONE when remaining > 0.
- Readout handshake:
  - Transfer happens on o_rd_valid && i_rd_ready.
  - While o_rd_valid && !i_rd_ready, o_rd_* is held stable.
  - Back-to-back transfers sustain 1 record/cycle; a prefetch/skid register is required.
- Readout completion: after the final transfer, o_rd_valid drops, o_done pulses 1 cycle, state goes IDLE and o_count reads 0. If DONE is entered with count 0 (impossible except by arm/abort races), o_done pulses and the state returns to IDLE immediately.
- o_count decrements on each transfer.
- Simultaneous write and trigger on the wrap slot: the write and the overflow set occur in the same cycle.

Decomposition:
- Package trace_pkg holds:
  - state encodings IDLE/ARMED/POST/DONE;
  - record field widths and the packed record width function (3*DATA_W + 1 + REG_AW);
  - MODE_FILLSTOP = 0 and MODE_CIRCULAR = 1.
- One sub-module, trace_ram: simple dual-port, DEPTH x record width, synchronous write, registered 1-cycle read.

Test Plan:
- Reset mid-POST (POST_TRIG=16, 5 records after trigger), then reset=1 for 1 cycle -> o_state 0, o_count 0, o_rd_valid 0, o_overflow 0.
- MODE 0, DEPTH=8, arm, then 10 commits pc=0x100,0x104..0x124 -> DONE after the 8th. Drains pc 0x100..0x11C in order, o_overflow 0, one o_done pulse.
- MODE 1, DEPTH=8, POST_TRIG=2, i_trig_pc=0x140, commits pc 0x100+4k for k=0..20:
  - -> trigger at 0x140 (k=16), DONE after 0x148.
  - -> drains 8 records 0x12C..0x148, o_overflow 1.
- POST_TRIG=0, trigger on the 3rd commit, pc 0x008, wb_en=1, addr=5, data=0xDEADBEEF -> DONE next cycle. Drains 3 records, the last with addr 5 and data 0xDEADBEEF.
- Readout backpressure: i_rd_ready toggles 1,0,0,1 -> o_rd_* stable during stall cycles, no duplicated or dropped records. o_count decrements only on transfers.
- i_arm during DONE with 4 records pending -> o_rd_valid 0 next cycle, ARMED, o_count 0, no o_done pulse.
